pwm_peripheral: RTL and testbench

Consumes the five configuration registers written over SPI and drives 16 digital outputs. Each output is forced low, forced high, or driven by a shared 8-bit PWM waveform. A free-running prescaler and 8-bit period counter generate the waveform (default ≈3 kHz at 10 MHz clk). The duty value is double-buffered and applied only at period boundaries, so SPI writes never produce glitched or truncated pulses.

---
 rtl/pwm_peripheral.sv | 106 ++++++++++
 tb/tb_pwm_peripheral.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_peripheral.sv
// pwm_peripheral
//
// Drives 16 digital outputs from the SPI configuration registers. Each output
// can be forced low, forced high, or driven by one shared 8-bit PWM waveform.
// A free-running prescaler divides clk by CLK_DIV. Each prescaler wrap advances
// an 8-bit period counter, so one PWM period lasts 256*CLK_DIV clk cycles.
// The requested duty is copied into a shadow register only at the period wrap,
// so an SPI write can never glitch or truncate a pulse.
//
// Parameters:
//   CLK_DIV          clk cycles per PWM counter step (1..65535)
//
// Ports:
//   clk              peripheral clock
//   rst_n            asynchronous active-low reset
//   en_reg_out_7_0   output enable, bits 7:0   (1 = output active)
//   en_reg_out_15_8  output enable, bits 15:8
//   en_reg_pwm_7_0   PWM select, bits 7:0      (1 = PWM waveform, 0 = static high)
//   en_reg_pwm_15_8  PWM select, bits 15:8
//   pwm_duty_cycle   requested duty, 0x00 = 0 %, 0xFF = 100 %
//   out_7_0          registered outputs 7:0
//   out_15_8         registered outputs 15:8
//   pwm_sync         registered one-cycle pulse in the first cycle of each period

module pwm_peripheral #(
  parameter int CLK_DIV = 13
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] en_reg_out_7_0,
  input  logic [7:0] en_reg_out_15_8,
  input  logic [7:0] en_reg_pwm_7_0,
  input  logic [7:0] en_reg_pwm_15_8,
  input  logic [7:0] pwm_duty_cycle,
  output logic [7:0] out_7_0,
  output logic [7:0] out_15_8,
  output logic       pwm_sync
);

  // Last prescaler value before it wraps. With CLK_DIV=1 this is 0, so every
  // cycle is a tick.
  localparam logic [15:0] PRESC_MAX = 16'(CLK_DIV - 1);

  logic [15:0] prescaler_q, prescaler_d;
  logic [7:0]  count_q, count_d;
  logic [7:0]  duty_shadow_q, duty_shadow_d;
  logic [15:0] out_q, out_d;
  logic        pwm_sync_q, pwm_sync_d;

  logic        tick;
  logic        wrap;
  logic        pwm_raw;
  logic [15:0] en_out;
  logic [15:0] en_pwm;

  assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
  assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

  always_comb begin
    tick          = (prescaler_q == PRESC_MAX);
    // The wrap edge ends one period and starts the next one.
    wrap          = tick && (count_q == 8'hFF);

    prescaler_d   = tick ? 16'd0 : prescaler_q + 16'd1;
    // The 8-bit add wraps 255 -> 0 on its own, so the wrap needs no extra cycle.
    count_d       = tick ? count_q + 8'd1 : count_q;

    // The duty is sampled only on the wrap edge. The value present on that
    // edge is the one that takes effect for the next period.
    duty_shadow_d = wrap ? pwm_duty_cycle : duty_shadow_q;

    // 0xFF means full period high. Otherwise the output is high for counts
    // 0..duty-1, so a duty of 0 gives a constant low output.
    pwm_raw       = (duty_shadow_q == 8'hFF) || (count_q < duty_shadow_q);

    // A cleared enable bit wins over the PWM select bit.
    out_d = '0;
    for (int i = 0; i < 16; i++) begin
      out_d[i] = en_out[i] ? (en_pwm[i] ? pwm_raw : 1'b1) : 1'b0;
    end

    // Registered, so the pulse lines up with the first cycle of count == 0.
    pwm_sync_d    = wrap;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler_q   <= '0;
      count_q       <= '0;
      duty_shadow_q <= '0;
      out_q         <= '0;
      pwm_sync_q    <= 1'b0;
    end else begin
      prescaler_q   <= prescaler_d;
      count_q       <= count_d;
      duty_shadow_q <= duty_shadow_d;
      out_q         <= out_d;
      pwm_sync_q    <= pwm_sync_d;
    end
  end

  assign out_7_0  = out_q[7:0];
  assign out_15_8 = out_q[15:8];
  assign pwm_sync = pwm_sync_q;

endmodule

// File: tb/tb_pwm_peripheral.sv
// Testbench for pwm_peripheral. Two instances share all inputs: one runs with
// CLK_DIV=2 and one with CLK_DIV=1. The driver computes the expected outputs
// for every clock edge from elapsed-cycle arithmetic and pushes them into a
// queue. The monitor pops one entry after each edge and compares it with the
// outputs of both instances.

module tb_pwm_peripheral;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [7:0] en_out_lo, en_out_hi, en_pwm_lo, en_pwm_hi, duty;
  logic [7:0] o2_lo, o2_hi, o1_lo, o1_hi;
  logic       s2, s1;

  pwm_peripheral #(.CLK_DIV(2)) u_dut_div2 (
    .clk             (clk),
    .rst_n           (rst_n),
    .en_reg_out_7_0  (en_out_lo),
    .en_reg_out_15_8 (en_out_hi),
    .en_reg_pwm_7_0  (en_pwm_lo),
    .en_reg_pwm_15_8 (en_pwm_hi),
    .pwm_duty_cycle  (duty),
    .out_7_0         (o2_lo),
    .out_15_8        (o2_hi),
    .pwm_sync        (s2)
  );

  pwm_peripheral #(.CLK_DIV(1)) u_dut_div1 (
    .clk             (clk),
    .rst_n           (rst_n),
    .en_reg_out_7_0  (en_out_lo),
    .en_reg_out_15_8 (en_out_hi),
    .en_reg_pwm_7_0  (en_pwm_lo),
    .en_reg_pwm_15_8 (en_pwm_hi),
    .pwm_duty_cycle  (duty),
    .out_7_0         (o1_lo),
    .out_15_8        (o1_hi),
    .pwm_sync        (s1)
  );

  typedef struct packed {
    logic [15:0] out2;
    logic        sync2;
    logic [15:0] out1;
    logic        sync1;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Settings the driver applies at the next falling edge.
  logic [15:0] cfg_en_out = '1;
  logic [15:0] cfg_en_pwm = '1;
  logic [7:0]  cfg_duty   = 8'hFF;
  logic        cfg_rst_n  = 1'b0;

  // Reference model state for index 0 (CLK_DIV=2) and index 1 (CLK_DIV=1).
  // m_n holds the number of rising edges since reset release.
  // m_shadow holds the duty that applies to the current period.
  int m_n[2];
  int m_shadow[2];

  function automatic int div_of(input int d);
    return (d == 0) ? 2 : 1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%h expected=%h", name, $time, act, exp);
    end
  endtask

  // Returns the expected outputs after the next rising edge and advances the model.
  task automatic model_edge(input int d, output logic [15:0] eo, output logic es);
    int   div;
    int   per;
    int   cnt;
    logic pwm;
    div = div_of(d);
    per = 256 * div;
    if (!cfg_rst_n) begin
      m_n[d]      = 0;
      m_shadow[d] = 0;
      eo          = '0;
      es          = 1'b0;
    end else begin
      // The output after edge n+1 reflects the counter as it stood after edge n.
      cnt = (m_n[d] / div) % 256;
      pwm = (m_shadow[d] == 255) || (cnt < m_shadow[d]);
      eo  = cfg_en_out & (~cfg_en_pwm | {16{pwm}});
      m_n[d]++;
      es  = ((m_n[d] % per) == 0);
      if (es) m_shadow[d] = int'(cfg_duty);
    end
  endtask

  task automatic step(input int ncyc);
    exp_t e;
    logic prev_rst_n;
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      prev_rst_n = rst_n;
      rst_n      = cfg_rst_n;
      en_out_lo  = cfg_en_out[7:0];
      en_out_hi  = cfg_en_out[15:8];
      en_pwm_lo  = cfg_en_pwm[7:0];
      en_pwm_hi  = cfg_en_pwm[15:8];
      duty       = cfg_duty;
      if (prev_rst_n && !cfg_rst_n) begin
        // Reset must clear the outputs without waiting for a clock edge.
        #1;
        check("async_rst_out_div2", 32'({o2_hi, o2_lo}), 32'd0);
        check("async_rst_out_div1", 32'({o1_hi, o1_lo}), 32'd0);
        check("async_rst_sync_div2", 32'(s2), 32'd0);
      end
      model_edge(0, e.out2, e.sync2);
      model_edge(1, e.out1, e.sync1);
      exp_q.push_back(e);
    end
  endtask

  // Steps at least once, then continues until the model for instance d is at
  // the given offset within its period. The loop is bounded.
  task automatic run_to_phase(input int d, input int phase);
    int per;
    per = 256 * div_of(d);
    step(1);
    for (int g = 0; g < 2 * per + 2; g++) begin
      if ((m_n[d] % per) == phase) break;
      step(1);
    end
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("out_div2",  32'({o2_hi, o2_lo}), 32'(e.out2));
        check("sync_div2", 32'(s2), 32'(e.sync2));
        check("out_div1",  32'({o1_hi, o1_lo}), 32'(e.out1));
        check("sync_div1", 32'(s1), 32'(e.sync1));
      end
    end
  end

  // Driver
  initial begin
    logic [7:0] sweep [5];
    int         r;
    sweep[0] = 8'h00; sweep[1] = 8'h01; sweep[2] = 8'h80; sweep[3] = 8'hFE; sweep[4] = 8'hFF;

    rst_n = 1'b0;
    en_out_lo = '1; en_out_hi = '1; en_pwm_lo = '1; en_pwm_hi = '1; duty = '1;

    // Hold reset with all inputs at 0xFF, then release. The first period stays low.
    step(5);
    cfg_rst_n = 1'b1;
    step(600);

    // Static mix: outputs are enabled but no PWM is selected.
    cfg_en_out = 16'h0FF0; cfg_en_pwm = 16'h0000;
    step(3 * 512 + 10);

    // Duty sweep: all outputs enabled and PWM-selected.
    cfg_en_out = '1; cfg_en_pwm = '1;
    foreach (sweep[i]) begin
      cfg_duty = sweep[i];
      run_to_phase(0, 0);
      step(2 * 512);
    end

    // Mid-period write: 0xC0 arrives at count 0x20 while 0x40 is running.
    cfg_duty = 8'h40;
    run_to_phase(0, 0);
    run_to_phase(0, 2 * 8'h20);
    cfg_duty = 8'hC0;
    step(2 * 512 + 20);

    // Enable dominance on bit 3.
    cfg_duty = 8'hFF;
    run_to_phase(0, 0);
    cfg_en_out = 16'hFFF7;
    step(600);
    cfg_en_out = 16'hFFFF;
    step(20);

    // Reset mid-period in the CLK_DIV=1 instance while its output is high (count 8, duty 0x10).
    cfg_duty = 8'h10;
    run_to_phase(1, 0);
    run_to_phase(1, 9);
    cfg_rst_n = 1'b0;
    step(3);
    cfg_rst_n = 1'b1;
    step(2 * 512 + 10);

    // Randomized segments.
    for (int s = 0; s < 40; s++) begin
      cfg_en_out = 16'($urandom);
      cfg_en_pwm = 16'($urandom);
      r = int'($urandom_range(0, 5));
      case (r)
        0:       cfg_duty = 8'h00;
        1:       cfg_duty = 8'hFF;
        2:       cfg_duty = 8'h01;
        3:       cfg_duty = 8'hFE;
        default: cfg_duty = 8'($urandom);
      endcase
      if ($urandom_range(0, 14) == 0) begin
        cfg_rst_n = 1'b0;
        step(2);
        cfg_rst_n = 1'b1;
      end
      step(int'($urandom_range(1, 400)));
    end

    step(3);
    repeat (3) @(posedge clk);
    #2;
    check("queue_drain", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
